pc_update_unit: RTL and testbench
=================================

Name: pc_update_unit

Overview:
Program-counter stage of the multicycle MIPS datapath. It sits directly downstream of the jump-address shifter: it consumes the 28-bit shifted jump field and selects among sequential, branch, jump, register and return-from-exception targets. It holds the PC and EPC registers. It also runs the exception-entry sequence, which saves EPC, reads the handler byte from memory, and redirects the PC to that handler.

Parameters:
MEM_LAT, 2, cycles the memory needs from a stable vec_addr to a valid vec_byte (minimum 1)
VEC_OPCODE, 253, memory address of the handler byte for an invalid opcode
VEC_OVF, 254, memory address of the handler byte for arithmetic overflow
VEC_DIV0, 255, memory address of the handler byte for divide by zero

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
pc_write  in  1  unconditional PC write enable
pc_write_cond  in  1  conditional PC write enable (branches)
branch_sel  in  2  00 beq (zero), 01 bne (!zero), 10 ble (zero|!gt), 11 bgt (gt)
zero  in  1  ALU zero flag
gt  in  1  ALU greater-than flag
pc_source  in  3  000 alu_result, 001 alu_out, 010 jump, 011 epc, 100 reg_a, 101-111 reserved
alu_result  in  32  PC+4 from the ALU
alu_out  in  32  registered branch target
jump_field  in  28  {instr[25:0], 2'b00} from the shifter
reg_a  in  32  register A (jr)
exc_req  in  1  exception request, one cycle
exc_cause  in  2  00 opcode, 01 overflow, 10 div0, 11 treated as 00
vec_byte  in  8  memory read data for the handler byte
vec_addr  out  32  handler-byte address
vec_rd  out  1  memory read request during exception entry
exc_busy  out  1  high while the exception sequence is active
pc  out  32  program counter
epc  out  32  exception program counter

Behaviour:
- Reset (sampled on a clk edge): pc=0, epc=0, state=RUN, cnt=0, vec_rd=0, vec_addr=0, exc_busy=0.
- Reset has priority over everything, including an in-progress exception sequence, which it aborts.
- States: RUN, WAIT, LOAD.
- exc_busy = (state != RUN). vec_rd = (state == WAIT or LOAD).
- vec_addr shows the latched cause's vector in WAIT/LOAD and 0 in RUN.
- RUN, target selection:
  - Jump target = {pc[31:28], jump_field}, using the current pc.
  - Condition cond is decoded from branch_sel per the port list.
- RUN, PC write:
  - pc is loaded with the target at the edge when pc_write | (pc_write_cond & cond).
  - pc_write and pc_write_cond both high: pc is written.
  - Reserved pc_source (101-111) holds pc even when enabled.
  - pc is not modified by this block's own sequencing; +4 comes only via alu_result.
- RUN, exc_req=1 at an edge:
  - exc_req has priority over any pc write in the same cycle; pc is held.
  - epc <= pc - 4, mod 2^32 (pc=0 gives FFFFFFFC).
  - cause is latched, cnt <= 0, state -> WAIT.
- WAIT: at each edge cnt <= cnt+1. When cnt == MEM_LAT-1, state -> LOAD.
- LOAD: at the edge, pc <= {24'h0, vec_byte} and state -> RUN.
- Latency: exc_req sampled at edge k:
  - vec_rd is high for MEM_LAT+1 cycles, from after edge k through edge k+MEM_LAT+1.
  - The new pc is visible after edge k+MEM_LAT+1. For MEM_LAT=2, pc updates at edge k+3.
- While in WAIT or LOAD: pc_write, pc_write_cond and exc_req are ignored (no nesting, no queuing), and epc is held.
- rte (pc_source=011 with pc_write) copies epc to pc; epc is unchanged.
- epc changes only on exception entry or reset.

Test Plan:
- Reset asserted with pc previously 0x00400010 -> pc=0, epc=0, vec_rd=0, exc_busy=0 after the edge.
- pc=0x10000000, jump_field=0x0ABCDE4, pc_source=010, pc_write=1 -> pc=0x10ABCDE4 next edge. Then pc_source=111, pc_write=1 -> pc unchanged.
- pc_write_cond=1, branch_sel=00, alu_out=0x40: with zero=1, pc becomes 0x40; with zero=0, pc holds. Repeat for bne, ble and bgt, including ble with zero=0 and gt=0 -> branch taken.
- pc=0x24, exc_req=1, exc_cause=01, pc_write=1, alu_result=0x28 in the same cycle (MEM_LAT=2), vec_byte=0x80:
  - epc=0x20 and pc stays 0x24 on the entry edge; the 0x28 write is ignored.
  - vec_addr=254 with vec_rd high for 3 cycles; pc=0x80 at edge k+3.
  - exc_busy is low afterwards, and a second exc_req during WAIT is ignored.
- Exception with pc=0 and cause 11 -> epc=0xFFFFFFFC, vec_addr=253. Then pc_source=011, pc_write=1 -> pc=0xFFFFFFFC.
- reset asserted during WAIT -> next edge state RUN, pc=0, epc=0, vec_rd=0, exc_busy=0; a subsequent normal pc_write works.

Source files
------------

// File: rtl/pc_update_unit.sv
// rtl/pc_update_unit.sv - PC/EPC registers, next-PC target select and exception-entry sequencer
// Vector fetch waits MEM_LAT cycles on a stable vec_addr, then loads the handler byte into pc.
module pc_update_unit #(
  parameter int MEM_LAT    = 2,
  parameter int VEC_OPCODE = 253,
  parameter int VEC_OVF    = 254,
  parameter int VEC_DIV0   = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_write,
  input  logic        pc_write_cond,
  input  logic [1:0]  branch_sel,
  input  logic        zero,
  input  logic        gt,
  input  logic [2:0]  pc_source,
  input  logic [31:0] alu_result,
  input  logic [31:0] alu_out,
  input  logic [27:0] jump_field,
  input  logic [31:0] reg_a,
  input  logic        exc_req,
  input  logic [1:0]  exc_cause,
  input  logic [7:0]  vec_byte,
  output logic [31:0] vec_addr,
  output logic        vec_rd,
  output logic        exc_busy,
  output logic [31:0] pc,
  output logic [31:0] epc
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    LOAD = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              cond;
  logic [31:0]       target;
  logic              target_valid;
  logic              pc_en;

  function automatic logic [31:0] vec_for(input logic [1:0] cause);
    case (cause)
      2'b01:   vec_for = 32'(VEC_OVF);
      2'b10:   vec_for = 32'(VEC_DIV0);
      default: vec_for = 32'(VEC_OPCODE);
    endcase
  endfunction

  always_comb begin
    cond = 1'b0;
    case (branch_sel)
      2'b00: cond = zero;
      2'b01: cond = ~zero;
      2'b10: cond = zero | ~gt;
      2'b11: cond = gt;
      default: cond = 1'b0;
    endcase
  end

  // Reserved sources leave target_valid low so an enabled write holds pc.
  always_comb begin
    target       = pc;
    target_valid = 1'b1;
    case (pc_source)
      3'b000: target = alu_result;
      3'b001: target = alu_out;
      3'b010: target = {pc[31:28], jump_field};
      3'b011: target = epc;
      3'b100: target = reg_a;
      default: target_valid = 1'b0;
    endcase
  end

  assign pc_en = (pc_write | (pc_write_cond & cond)) & target_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= 32'h0;
      epc      <= 32'h0;
      state    <= RUN;
      cnt      <= '0;
      vec_rd   <= 1'b0;
      vec_addr <= 32'h0;
      exc_busy <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (exc_req) begin
            epc      <= pc - 32'd4;
            vec_addr <= vec_for(exc_cause);
            cnt      <= '0;
            state    <= WAIT;
            vec_rd   <= 1'b1;
            exc_busy <= 1'b1;
          end else if (pc_en) begin
            pc <= target;
          end
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(MEM_LAT - 1)) begin
            state <= LOAD;
          end
        end
        LOAD: begin
          pc       <= {24'h0, vec_byte};
          state    <= RUN;
          vec_rd   <= 1'b0;
          vec_addr <= 32'h0;
          exc_busy <= 1'b0;
        end
        default: begin
          state    <= RUN;
          vec_rd   <= 1'b0;
          vec_addr <= 32'h0;
          exc_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_update_unit.sv
// tb/tb_pc_update_unit.sv - directed self-checking bench for pc_update_unit
module tb_pc_update_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_write;
  logic        pc_write_cond;
  logic [1:0]  branch_sel;
  logic        zero;
  logic        gt;
  logic [2:0]  pc_source;
  logic [31:0] alu_result;
  logic [31:0] alu_out;
  logic [27:0] jump_field;
  logic [31:0] reg_a;
  logic        exc_req;
  logic [1:0]  exc_cause;
  logic [7:0]  vec_byte;
  logic [31:0] vec_addr;
  logic        vec_rd;
  logic        exc_busy;
  logic [31:0] pc;
  logic [31:0] epc;

  int n_cmp = 0;
  int n_bad = 0;

  // {branch_sel, zero, gt, taken}
  logic [4:0] br_tbl [0:8] = '{
    5'b00_1_0_1, 5'b00_0_0_0, 5'b01_0_0_1, 5'b01_1_0_0, 5'b10_0_0_1,
    5'b10_1_1_1, 5'b10_0_1_0, 5'b11_0_1_1, 5'b11_0_0_0
  };

  always #5 clk = ~clk;

  pc_update_unit #(.MEM_LAT(2), .VEC_OPCODE(253), .VEC_OVF(254), .VEC_DIV0(255)) dut (
    .clk(clk), .reset(reset), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .branch_sel(branch_sel), .zero(zero), .gt(gt), .pc_source(pc_source),
    .alu_result(alu_result), .alu_out(alu_out), .jump_field(jump_field), .reg_a(reg_a),
    .exc_req(exc_req), .exc_cause(exc_cause), .vec_byte(vec_byte), .vec_addr(vec_addr),
    .vec_rd(vec_rd), .exc_busy(exc_busy), .pc(pc), .epc(epc)
  );

  task automatic idle();
    reset = 1'b0; pc_write = 1'b0; pc_write_cond = 1'b0; branch_sel = 2'b00;
    zero = 1'b0; gt = 1'b0; pc_source = 3'b000; alu_result = 32'h0; alu_out = 32'h0;
    jump_field = 28'h0; reg_a = 32'h0; exc_req = 1'b0; exc_cause = 2'b00;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_pc(input logic [31:0] v);
    idle();
    pc_write = 1'b1; pc_source = 3'b000; alu_result = v;
    step();
    idle();
  endtask

  task automatic test_reset();
    set_pc(32'h0040_0010);
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_cmp++; if (pc !== 32'h0) begin n_bad++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
    n_cmp++; if (epc !== 32'h0) begin n_bad++; $display("FAIL reset_epc: got %h want %h", epc, 32'h0); end
    n_cmp++; if (vec_rd !== 1'b0) begin n_bad++; $display("FAIL reset_vec_rd: got %b want 0", vec_rd); end
    n_cmp++; if (exc_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", exc_busy); end
    n_cmp++; if (vec_addr !== 32'h0) begin n_bad++; $display("FAIL reset_vec_addr: got %h want 0", vec_addr); end
  endtask

  task automatic test_jump();
    set_pc(32'h1000_0000);
    pc_write = 1'b1; pc_source = 3'b010; jump_field = 28'h0ABCDE4;
    step();
    idle();
    n_cmp++; if (pc !== 32'h10AB_CDE4) begin n_bad++; $display("FAIL jump_pc: got %h want %h", pc, 32'h10AB_CDE4); end
    pc_write = 1'b1; pc_source = 3'b111; alu_result = 32'h1234;
    step();
    idle();
    n_cmp++; if (pc !== 32'h10AB_CDE4) begin n_bad++; $display("FAIL reserved_src: got %h want %h", pc, 32'h10AB_CDE4); end
    reg_a = 32'h0000_5550; pc_write = 1'b1; pc_source = 3'b100;
    step();
    idle();
    n_cmp++; if (pc !== 32'h0000_5550) begin n_bad++; $display("FAIL jr_pc: got %h want %h", pc, 32'h0000_5550); end
  endtask

  task automatic test_branch();
    logic [31:0] want;
    for (int i = 0; i < 9; i++) begin
      set_pc(32'h8);
      pc_write_cond = 1'b1; pc_source = 3'b001; alu_out = 32'h40;
      branch_sel = br_tbl[i][4:3]; zero = br_tbl[i][2]; gt = br_tbl[i][1];
      step();
      idle();
      want = br_tbl[i][0] ? 32'h40 : 32'h8;
      n_cmp++;
      if (pc !== want) begin
        n_bad++; $display("FAIL branch_%0d sel=%b z=%b gt=%b: got %h want %h",
                          i, br_tbl[i][4:3], br_tbl[i][2], br_tbl[i][1], pc, want);
      end
    end
    // unconditional write wins even when the branch condition is false
    set_pc(32'h8);
    pc_write = 1'b1; pc_write_cond = 1'b1; branch_sel = 2'b00; zero = 1'b0;
    pc_source = 3'b001; alu_out = 32'h60;
    step();
    idle();
    n_cmp++; if (pc !== 32'h60) begin n_bad++; $display("FAIL both_enables: got %h want %h", pc, 32'h60); end
  endtask

  task automatic test_exception();
    set_pc(32'h24);
    vec_byte = 8'h80;
    exc_req = 1'b1; exc_cause = 2'b01; pc_write = 1'b1; pc_source = 3'b000; alu_result = 32'h28;
    step();
    idle();
    n_cmp++; if (epc !== 32'h20) begin n_bad++; $display("FAIL exc_epc: got %h want %h", epc, 32'h20); end
    n_cmp++; if (pc !== 32'h24) begin n_bad++; $display("FAIL exc_pc_hold: got %h want %h", pc, 32'h24); end
    n_cmp++; if (vec_addr !== 32'd254) begin n_bad++; $display("FAIL exc_vec_addr: got %0d want 254", vec_addr); end
    n_cmp++; if (vec_rd !== 1'b1) begin n_bad++; $display("FAIL exc_vec_rd_c1: got %b want 1", vec_rd); end
    n_cmp++; if (exc_busy !== 1'b1) begin n_bad++; $display("FAIL exc_busy_c1: got %b want 1", exc_busy); end
    // nested request and pc write during WAIT are ignored
    exc_req = 1'b1; exc_cause = 2'b10; pc_write = 1'b1; alu_result = 32'h99;
    step();
    idle();
    n_cmp++; if (vec_rd !== 1'b1) begin n_bad++; $display("FAIL exc_vec_rd_c2: got %b want 1", vec_rd); end
    n_cmp++; if (vec_addr !== 32'd254) begin n_bad++; $display("FAIL exc_nested_addr: got %0d want 254", vec_addr); end
    n_cmp++; if (epc !== 32'h20) begin n_bad++; $display("FAIL exc_nested_epc: got %h want %h", epc, 32'h20); end
    n_cmp++; if (pc !== 32'h24) begin n_bad++; $display("FAIL exc_wait_pc: got %h want %h", pc, 32'h24); end
    step();
    n_cmp++; if (vec_rd !== 1'b1) begin n_bad++; $display("FAIL exc_vec_rd_c3: got %b want 1", vec_rd); end
    n_cmp++; if (pc !== 32'h24) begin n_bad++; $display("FAIL exc_early_pc: got %h want %h", pc, 32'h24); end
    step();
    n_cmp++; if (pc !== 32'h80) begin n_bad++; $display("FAIL exc_handler_pc: got %h want %h", pc, 32'h80); end
    n_cmp++; if (vec_rd !== 1'b0) begin n_bad++; $display("FAIL exc_vec_rd_end: got %b want 0", vec_rd); end
    n_cmp++; if (exc_busy !== 1'b0) begin n_bad++; $display("FAIL exc_busy_end: got %b want 0", exc_busy); end
    n_cmp++; if (vec_addr !== 32'h0) begin n_bad++; $display("FAIL exc_vec_addr_end: got %h want 0", vec_addr); end
    n_cmp++; if (epc !== 32'h20) begin n_bad++; $display("FAIL exc_epc_end: got %h want %h", epc, 32'h20); end
  endtask

  task automatic test_exc_pc0_rte();
    set_pc(32'h0);
    vec_byte = 8'h11;
    exc_req = 1'b1; exc_cause = 2'b11;
    step();
    idle();
    n_cmp++; if (epc !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL pc0_epc: got %h want %h", epc, 32'hFFFF_FFFC); end
    n_cmp++; if (vec_addr !== 32'd253) begin n_bad++; $display("FAIL cause3_vec_addr: got %0d want 253", vec_addr); end
    step();
    step();
    step();
    n_cmp++; if (pc !== 32'h11) begin n_bad++; $display("FAIL pc0_handler: got %h want %h", pc, 32'h11); end
    pc_write = 1'b1; pc_source = 3'b011;
    step();
    idle();
    n_cmp++; if (pc !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL rte_pc: got %h want %h", pc, 32'hFFFF_FFFC); end
    n_cmp++; if (epc !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL rte_epc: got %h want %h", epc, 32'hFFFF_FFFC); end
  endtask

  task automatic test_reset_during_wait();
    set_pc(32'h100);
    vec_byte = 8'h77;
    exc_req = 1'b1; exc_cause = 2'b10;
    step();
    idle();
    n_cmp++; if (vec_addr !== 32'd255) begin n_bad++; $display("FAIL div0_vec_addr: got %0d want 255", vec_addr); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_cmp++; if (pc !== 32'h0) begin n_bad++; $display("FAIL abort_pc: got %h want 0", pc); end
    n_cmp++; if (epc !== 32'h0) begin n_bad++; $display("FAIL abort_epc: got %h want 0", epc); end
    n_cmp++; if (vec_rd !== 1'b0) begin n_bad++; $display("FAIL abort_vec_rd: got %b want 0", vec_rd); end
    n_cmp++; if (exc_busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", exc_busy); end
    pc_write = 1'b1; pc_source = 3'b000; alu_result = 32'h44;
    step();
    idle();
    n_cmp++; if (pc !== 32'h44) begin n_bad++; $display("FAIL post_abort_write: got %h want %h", pc, 32'h44); end
    step();
    step();
    n_cmp++; if (pc !== 32'h44) begin n_bad++; $display("FAIL post_abort_hold: got %h want %h", pc, 32'h44); end
  endtask

  initial begin
    idle();
    vec_byte = 8'h00;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    test_reset();
    test_jump();
    test_branch();
    test_exception();
    test_exc_pc0_rte();
    test_reset_during_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
